// File: rtl/control_sequencer.sv
// Moore control unit sequencing fetch (T0-T2) and execute (T3-T5) of
// register-register ALU instructions by driving the datapath's one-hot strobes.
module control_sequencer #(
    parameter logic [4:0] OPC_ADD  = 5'b00011,
    parameter logic [4:0] OPC_SUB  = 5'b00100,
    parameter logic [4:0] OPC_AND  = 5'b00101,
    parameter logic [4:0] OPC_OR   = 5'b00110,
    parameter logic [4:0] OPC_HALT = 5'b11011
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Run,
    input  logic        Mem_ready,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        Rout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Rin,
    output logic        IncPC,
    output logic        Read,
    output logic        ADD,
    output logic        SUB,
    output logic        AND,
    output logic        OR,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Done,
    output logic        Halted,
    output logic        Illegal
);

    // T1 is split so PCin fires only on the first fetch-wait cycle.
    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_HALT
    } state_e;

    state_e      state_q, state_d;
    logic        illegal_q, illegal_d;
    logic [4:0]  opcode;
    logic        is_alu;
    logic        ir_unused;

    assign opcode    = IR[31:27];
    assign ir_unused = ^IR[26:0];
    assign is_alu    = (opcode == OPC_ADD) || (opcode == OPC_SUB) ||
                       (opcode == OPC_AND) || (opcode == OPC_OR);
    assign Illegal   = illegal_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        PCout     = 1'b0;
        Zlowout   = 1'b0;
        MDRout    = 1'b0;
        Rout      = 1'b0;
        MARin     = 1'b0;
        Zin       = 1'b0;
        PCin      = 1'b0;
        MDRin     = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Rin       = 1'b0;
        IncPC     = 1'b0;
        Read      = 1'b0;
        ADD       = 1'b0;
        SUB       = 1'b0;
        AND       = 1'b0;
        OR        = 1'b0;
        Gra       = 1'b0;
        Grb       = 1'b0;
        Grc       = 1'b0;
        Done      = 1'b0;
        Halted    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (Run) state_d = S_T0;
            end
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                state_d = Mem_ready ? S_T2 : S_T1W;
            end
            S_T1W: begin
                Read  = 1'b1;
                MDRin = 1'b1;
                if (Mem_ready) state_d = S_T2;
            end
            S_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                if (is_alu) begin
                    Grb     = 1'b1;
                    Rout    = 1'b1;
                    Yin     = 1'b1;
                    state_d = S_T4;
                end else begin
                    illegal_d = (opcode != OPC_HALT);
                    state_d   = S_HALT;
                end
            end
            S_T4: begin
                Grc     = 1'b1;
                Rout    = 1'b1;
                Zin     = 1'b1;
                ADD     = (opcode == OPC_ADD);
                SUB     = (opcode == OPC_SUB);
                AND     = (opcode == OPC_AND);
                OR      = (opcode == OPC_OR);
                state_d = S_T5;
            end
            S_T5: begin
                Zlowout = 1'b1;
                Gra     = 1'b1;
                Rin     = 1'b1;
                Done    = 1'b1;
                state_d = Run ? S_T0 : S_IDLE;
            end
            S_HALT: begin
                Halted = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
